axi_burst_master: RTL and testbench

- AXI4 initiator that turns a simple command stream into single AXI4 INCR bursts of 1-16 beats, one at a time.
- Drives the AW/W/B or AR/R channels and hands read data and completion status back to the client.
- Acts as the traffic source and test initiator for the AXI4 DDR memory slave. Follows the same subset: aligned addresses, full-width beats, 4-bit length, INCR only.

---
 rtl/axi_pkg.sv | 36 +++
 rtl/axi_burst_master.sv | 249 ++++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the burst master: response codes, FSM state
// encoding, the 4KB address boundary and the worst-of response merge.
package axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // A burst must not touch bytes at or beyond the next 4KB page.
  localparam int unsigned AXI_4KB = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BURST,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } state_t;

  // Response codes are ordered by severity, so the worst of two is the max.
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // True when a burst starting at page offset 'offs' with len+1 beats of
  // 'beat_bytes' each would run past the end of the 4KB page.
  function automatic logic crosses_4kb(input logic [11:0] offs, input logic [3:0] len,
                                       input int unsigned beat_bytes);
    int unsigned end_byte;
    end_byte = 32'(offs) + (32'(len) + 32'd1) * beat_bytes;
    return end_byte > AXI_4KB;
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 initiator: turns a client command stream into one INCR burst at a
// time (1-16 full-width beats), passes write/read beats straight through and
// reports a single completion status per burst.
// Optional build macro: AXI_BURST_MASTER_4K_CHECK_EN rejects commands whose
// burst would cross a 4KB page (completed as SLVERR without AXI traffic).
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ID         = 0
) (
  input  logic                      aclk,
  input  logic                      areset,
  // client command
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [3:0]                cmd_len,
  // client write beats
  input  logic [AXI_DATA_WIDTH-1:0] wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  // client read beats
  output logic [AXI_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_last,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  // client completion
  output logic                      done_valid,
  input  logic                      done_ready,
  output logic                      done_write,
  output logic [1:0]                done_resp,
  // AXI write address
  output logic [AXI_ADDR_WIDTH-1:0] awaddr,
  output logic [AXI_ID_WIDTH-1:0]   awid,
  output logic [7:0]                awlen,
  output logic                      awvalid,
  input  logic                      awready,
  // AXI write data
  output logic [AXI_DATA_WIDTH-1:0] wdata,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  // AXI write response
  input  logic [AXI_ID_WIDTH-1:0]   bid,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  // AXI read address
  output logic [AXI_ADDR_WIDTH-1:0] araddr,
  output logic [AXI_ID_WIDTH-1:0]   arid,
  output logic [7:0]                arlen,
  output logic                      arvalid,
  input  logic                      arready,
  // AXI read data
  input  logic [AXI_ID_WIDTH-1:0]   rid,
  input  logic [AXI_DATA_WIDTH-1:0] rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready
);

  localparam logic [AXI_ID_WIDTH-1:0] ID_C = AXI_ID_WIDTH'(AXI_ID);
`ifdef AXI_BURST_MASTER_4K_CHECK_EN
  localparam int unsigned BEAT_BYTES = AXI_DATA_WIDTH / 8;
`endif

  state_t                      state;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [3:0]                  len_q;
  logic [3:0]                  beat_cnt;
  logic [1:0]                  resp_acc;
  logic                        aw_done;   // AW handshake already taken
  logic                        w_done;    // wlast beat already taken
  logic                        cmd_ready_q;
  logic                        awvalid_q;
  logic                        arvalid_q;
  logic                        bready_q;
  logic                        done_valid_q;
  logic                        done_write_q;
  logic [1:0]                  done_resp_q;

  logic last_beat;
  logic in_wr, in_rd;
  logic cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire, done_fire;
  logic [1:0] beat_resp, resp_next;

  assign last_beat = (beat_cnt == len_q);

  // Beat passthroughs are only open in their burst state and never while
  // reset is asserted, so no handshake can complete on a reset cycle.
  assign in_wr = (state == ST_WR_BURST) && !w_done && !areset;
  assign in_rd = (state == ST_RD_DATA) && !areset;

  assign wvalid   = in_wr && wr_valid;
  assign wr_ready = in_wr && wready;
  assign wdata    = wr_data;
  assign wlast    = last_beat;

  assign rd_valid = in_rd && rvalid;
  assign rready   = in_rd && rd_ready;
  assign rd_data  = rdata;
  assign rd_last  = rlast;

  assign cmd_ready  = cmd_ready_q  && !areset;
  assign awvalid    = awvalid_q    && !areset;
  assign arvalid    = arvalid_q    && !areset;
  assign bready     = bready_q     && !areset;
  assign done_valid = done_valid_q && !areset;
  assign done_write = done_write_q;
  assign done_resp  = done_resp_q;

  assign awaddr = addr_q;
  assign awlen  = {4'b0000, len_q};
  assign awid   = ID_C;
  assign araddr = addr_q;
  assign arlen  = {4'b0000, len_q};
  assign arid   = ID_C;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign aw_fire   = awvalid && awready;
  assign w_fire    = wvalid && wready;
  assign b_fire    = bvalid && bready;
  assign ar_fire   = arvalid && arready;
  assign r_fire    = rvalid && rready;
  assign done_fire = done_valid && done_ready;

  // Severity of the current read beat folded into the running worst-of.
  always_comb begin
    beat_resp = rresp;
    if (rid != ID_C)         beat_resp = resp_merge(beat_resp, AXI_RESP_SLVERR);
    if (rlast != last_beat)  beat_resp = resp_merge(beat_resp, AXI_RESP_SLVERR);
    resp_next = resp_merge(resp_acc, beat_resp);
  end

  // Burst sequencer: one command in flight, registered channel controls.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      beat_cnt     <= '0;
      resp_acc     <= AXI_RESP_OKAY;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      cmd_ready_q  <= 1'b0;
      awvalid_q    <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      done_valid_q <= 1'b0;
      done_write_q <= 1'b0;
      done_resp_q  <= AXI_RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= cmd_addr;
            len_q       <= cmd_len;
            beat_cnt    <= '0;
            resp_acc    <= AXI_RESP_OKAY;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
`ifdef AXI_BURST_MASTER_4K_CHECK_EN
            if (crosses_4kb(cmd_addr[11:0], cmd_len, BEAT_BYTES)) begin
              // Accepted but never issued: straight to an error completion.
              state        <= ST_DONE;
              done_valid_q <= 1'b1;
              done_write_q <= cmd_write;
              done_resp_q  <= AXI_RESP_SLVERR;
            end else
`endif
            if (cmd_write) begin
              state     <= ST_WR_BURST;
              awvalid_q <= 1'b1;
            end else begin
              state     <= ST_RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end

        ST_WR_BURST: begin
          if (aw_fire) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_fire) begin
            if (last_beat) w_done <= 1'b1;
            else           beat_cnt <= beat_cnt + 4'd1;
          end
          // AW and the wlast beat may finish in either order or together.
          if ((aw_done || aw_fire) && (w_done || (w_fire && last_beat))) begin
            state    <= ST_WR_RESP;
            bready_q <= 1'b1;
          end
        end

        ST_WR_RESP: begin
          if (b_fire) begin
            bready_q     <= 1'b0;
            done_valid_q <= 1'b1;
            done_write_q <= 1'b1;
            done_resp_q  <= (bid != ID_C) ? AXI_RESP_SLVERR : bresp;
            state        <= ST_DONE;
          end
        end

        ST_RD_ADDR: begin
          if (ar_fire) begin
            arvalid_q <= 1'b0;
            state     <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (r_fire) begin
            resp_acc <= resp_next;
            // Terminate on count so a slave that never sends rlast cannot hang us.
            if (last_beat) begin
              done_valid_q <= 1'b1;
              done_write_q <= 1'b0;
              done_resp_q  <= resp_next;
              state        <= ST_DONE;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end

        ST_DONE: begin
          if (done_fire) begin
            done_valid_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
            state        <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master. Tests push spec-level expectations
// (AW/AR requests, W/RD beats, completions) into queues; one negedge monitor
// checks every meaningful DUT output against the heads of those queues.
`timescale 1ns/1ps
module tb_axi_burst_master;

  localparam logic [3:0] MY_ID = 4'h5;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [63:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [63:0] rd_data;
  logic        rd_last, rd_valid, rd_ready;
  logic        done_valid, done_ready, done_write;
  logic [1:0]  done_resp;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  axi_burst_master #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_ID(5)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done_valid(done_valid), .done_ready(done_ready), .done_write(done_write),
    .done_resp(done_resp),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  typedef struct packed { logic [31:0] addr; logic [3:0] len; } ax_t;
  typedef struct packed { logic [63:0] data; logic last; } beat_t;
  typedef struct packed { logic wr; logic [1:0] resp; } done_t;

  ax_t   exp_aw[$], exp_ar[$];
  beat_t exp_w[$], exp_rd[$];
  done_t exp_done[$];

  int checks = 0, failures = 0;
  int n_aw = 0, n_w = 0, n_r = 0;
  logic [1:0]  last_done_resp = 2'b00;
  logic        last_done_write = 1'b0;
  logic [63:0] last_rd_data = '0;
  bit stop_tog;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endfunction

  function automatic logic [63:0] wdata_for(input logic [15:0] tag, input int i);
    return {16'hA5A5, tag, 32'(i)};
  endfunction

  function automatic logic [63:0] rdata_for(input logic [31:0] addr, input int i);
    return {32'hDA7A_0000, addr + 32'(8 * i)};
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Monitor: compare outputs with the expectation queues every cycle.
  always @(negedge aclk) begin
    if (!areset) begin
      if (awvalid) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", awvalid, 0);
        else begin
          chk("awaddr", awaddr, exp_aw[0].addr);
          chk("awlen", awlen, {4'b0, exp_aw[0].len});
          chk("awid", awid, MY_ID);
          if (awready) begin void'(exp_aw.pop_front()); n_aw++; end
        end
      end
      if (wvalid) begin
        chk("w_pass_ready", wr_ready, wready);
        if (exp_w.size() == 0) chk("w_unexpected", wvalid, 0);
        else begin
          chk("wdata", wdata, exp_w[0].data);
          chk("wlast", wlast, exp_w[0].last);
          if (wready) begin void'(exp_w.pop_front()); n_w++; end
        end
      end
      if (arvalid) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", arvalid, 0);
        else begin
          chk("araddr", araddr, exp_ar[0].addr);
          chk("arlen", arlen, {4'b0, exp_ar[0].len});
          chk("arid", arid, MY_ID);
          if (arready) void'(exp_ar.pop_front());
        end
      end
      if (rd_valid) begin
        chk("r_pass_ready", rready, rd_ready);
        if (exp_rd.size() == 0) chk("rd_unexpected", rd_valid, 0);
        else begin
          chk("rd_data", rd_data, exp_rd[0].data);
          chk("rd_last", rd_last, exp_rd[0].last);
          if (rd_ready) begin last_rd_data = rd_data; void'(exp_rd.pop_front()); n_r++; end
        end
      end
      if (done_valid) begin
        if (exp_done.size() == 0) chk("done_unexpected", done_valid, 0);
        else begin
          chk("done_write", done_write, exp_done[0].wr);
          chk("done_resp", done_resp, exp_done[0].resp);
          if (done_ready) begin
            last_done_resp = done_resp;
            last_done_write = done_write;
            void'(exp_done.pop_front());
          end
        end
      end
    end
  end

  task automatic issue_cmd(input bit wr, input logic [31:0] addr, input logic [3:0] len);
    int t;
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    for (t = 0; t < 200; t++) begin @(negedge aclk); if (cmd_ready) break; end
    if (t == 200) timeout("cmd_accept");
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input logic [15:0] tag, input int nbeats, input int dly);
    int t;
    repeat (dly) @(posedge aclk);
    #1;
    for (int k = 0; k < nbeats; k++) begin
      wr_valid = 1'b1; wr_data = wdata_for(tag, k);
      for (t = 0; t < 200; t++) begin @(negedge aclk); if (wr_ready) break; end
      if (t == 200) timeout("w_beat");
      @(posedge aclk); #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic aw_slave(input int dly);
    int t;
    for (t = 0; t < 200; t++) begin @(negedge aclk); if (awvalid) break; end
    if (t == 200) timeout("aw_wait");
    @(posedge aclk);
    repeat (dly) @(posedge aclk);
    #1 awready = 1'b1;
    for (t = 0; t < 200; t++) begin @(negedge aclk); if (awvalid && awready) break; end
    if (t == 200) timeout("aw_hs");
    @(posedge aclk); #1 awready = 1'b0;
  endtask

  task automatic wait_done(input int dly);
    int t;
    for (t = 0; t < 400; t++) begin @(negedge aclk); if (done_valid) break; end
    if (t == 400) timeout("done_wait");
    @(posedge aclk);
    repeat (dly) @(posedge aclk);
    #1 done_ready = 1'b1;
    for (t = 0; t < 200; t++) begin @(negedge aclk); if (done_valid && done_ready) break; end
    if (t == 200) timeout("done_hs");
    @(posedge aclk); #1 done_ready = 1'b0;
    stop_tog = 1'b1;
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [3:0] len, input logic [15:0] tag,
                           input int aw_dly, input int data_dly, input bit thr,
                           input logic [1:0] resp, input logic [3:0] id, input int done_dly);
    ax_t a; beat_t b; done_t d; bit blocked; int t;
    blocked = 1'b0;
`ifdef AXI_BURST_MASTER_4K_CHECK_EN
    blocked = (int'(addr[11:0]) + (int'(len) + 1) * 8) > 4096;
`endif
    d.wr = 1'b1;
    if (blocked) d.resp = 2'b10;
    else begin
      a.addr = addr; a.len = len; exp_aw.push_back(a);
      for (int i = 0; i <= int'(len); i++) begin
        b.data = wdata_for(tag, i); b.last = (i == int'(len)); exp_w.push_back(b);
      end
      d.resp = (id != MY_ID) ? 2'b10 : resp;
    end
    exp_done.push_back(d);
    stop_tog = 1'b0;
    fork
      begin
        issue_cmd(1'b1, addr, len);
        if (!blocked) send_beats(tag, int'(len) + 1, data_dly);
      end
      begin
        if (!blocked) aw_slave(aw_dly);
      end
      begin
        if (!blocked) begin
          for (t = 0; t < 400; t++) begin @(negedge aclk); if (bready) break; end
          if (t == 400) timeout("b_wait");
          @(posedge aclk); #1;
          bvalid = 1'b1; bid = id; bresp = resp;
          for (t = 0; t < 200; t++) begin @(negedge aclk); if (bvalid && bready) break; end
          if (t == 200) timeout("b_hs");
          @(posedge aclk); #1;
          bvalid = 1'b0; bid = '0; bresp = '0;
        end
      end
      begin
        if (thr) begin
          while (!stop_tog) begin @(posedge aclk); #1 wready = ~wready; end
          wready = 1'b1;
        end
      end
      wait_done(done_dly);
    join
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [3:0] len, input int ar_dly,
                          input bit thr, input int err_beat, input logic [1:0] err_resp,
                          input int early_last, input logic [3:0] id, input int done_dly);
    ax_t a; beat_t b; done_t d; logic [1:0] r; int t;
    a.addr = addr; a.len = len; exp_ar.push_back(a);
    r = (id != MY_ID) ? 2'b10 : 2'b00;
    for (int i = 0; i <= int'(len); i++) begin
      b.data = rdata_for(addr, i);
      b.last = (i == int'(len)) || (i == early_last);
      exp_rd.push_back(b);
      if (i == err_beat) r = worst(r, err_resp);
      if (b.last != (i == int'(len))) r = worst(r, 2'b10);
    end
    d.wr = 1'b0; d.resp = r; exp_done.push_back(d);
    stop_tog = 1'b0;
    fork
      issue_cmd(1'b0, addr, len);
      begin
        for (t = 0; t < 200; t++) begin @(negedge aclk); if (arvalid) break; end
        if (t == 200) timeout("ar_wait");
        @(posedge aclk);
        repeat (ar_dly) @(posedge aclk);
        #1 arready = 1'b1;
        for (t = 0; t < 200; t++) begin @(negedge aclk); if (arvalid && arready) break; end
        if (t == 200) timeout("ar_hs");
        @(posedge aclk); #1 arready = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
          rvalid = 1'b1; rid = id; rdata = rdata_for(addr, i);
          rresp = (i == err_beat) ? err_resp : 2'b00;
          rlast = (i == int'(len)) || (i == early_last);
          for (t = 0; t < 200; t++) begin @(negedge aclk); if (rvalid && rready) break; end
          if (t == 200) timeout("r_beat");
          @(posedge aclk); #1;
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = '0; rid = '0;
      end
      begin
        if (thr) begin
          while (!stop_tog) begin @(posedge aclk); #1 rd_ready = ~rd_ready; end
          rd_ready = 1'b1;
        end
      end
      wait_done(done_dly);
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, aw0, r0;
    areset = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b1; rd_ready = 1'b1; done_ready = 1'b0;
    awready = 0; wready = 1'b1; bid = '0; bresp = '0; bvalid = 0;
    arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_resp", done_resp, 0);
    chk("rst_done_write", done_write, 0);
    @(posedge aclk); #1 areset = 1'b0; wr_valid = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    chk("idle_cmd_ready", cmd_ready, 1);

    // AW first, then data; OKAY.
    w0 = n_w; aw0 = n_aw;
    run_write(32'h100, 4'd3, 16'h0001, 0, 3, 1'b0, 2'b00, MY_ID, 0);
    chk("t1_beats", n_w - w0, 4);
    chk("t1_aw_count", n_aw - aw0, 1);
    chk("t1_resp", last_done_resp, 2'b00);
    chk("t1_write", last_done_write, 1);

    // Data first: all beats move well before awready; slow done_ready.
    w0 = n_w;
    run_write(32'h180, 4'd3, 16'h0002, 6, 0, 1'b0, 2'b00, MY_ID, 2);
    chk("t2_beats", n_w - w0, 4);

    // Single-beat write, DECERR passed back as-is.
    run_write(32'h40, 4'd0, 16'h0003, 0, 0, 1'b0, 2'b11, MY_ID, 0);
    chk("t3_resp", last_done_resp, 2'b11);

    // Wrong bid forces SLVERR; wready throttled.
    run_write(32'h800, 4'd7, 16'h0004, 2, 1, 1'b1, 2'b00, 4'h3, 1);
    chk("t4_resp", last_done_resp, 2'b10);

    // 16-beat read with rd_ready toggling.
    r0 = n_r;
    run_read(32'h2000, 4'd15, 0, 1'b1, -1, 2'b00, -1, MY_ID, 0);
    chk("t5_beats", n_r - r0, 16);
    chk("t5_last_data", last_rd_data, 64'hDA7A_0000_0000_2078);
    chk("t5_resp", last_done_resp, 2'b00);
    chk("t5_write", last_done_write, 0);

    // SLVERR on beat 0.
    run_read(32'h3000, 4'd1, 1, 1'b0, 0, 2'b10, -1, MY_ID, 0);
    chk("t6_resp", last_done_resp, 2'b10);

    // Early rlast on beat 0.
    run_read(32'h3100, 4'd1, 0, 1'b0, -1, 2'b00, 0, MY_ID, 0);
    chk("t7_resp", last_done_resp, 2'b10);

    // rid mismatch plus EXOKAY: worst is SLVERR.
    run_read(32'h3200, 4'd2, 0, 1'b0, 1, 2'b01, -1, 4'h9, 0);
    chk("t8_resp", last_done_resp, 2'b10);

    // EXOKAY alone survives the merge.
    run_read(32'h3300, 4'd0, 0, 1'b0, 0, 2'b01, -1, MY_ID, 0);
    chk("t9_resp", last_done_resp, 2'b01);

    // Reset in the middle of a write after two beats.
    begin
      ax_t a; beat_t b;
      a.addr = 32'h300; a.len = 4'd3; exp_aw.push_back(a);
      for (int i = 0; i < 2; i++) begin
        b.data = wdata_for(16'h00AA, i); b.last = 1'b0; exp_w.push_back(b);
      end
      fork
        begin issue_cmd(1'b1, 32'h300, 4'd3); send_beats(16'h00AA, 2, 0); end
        aw_slave(0);
      join
      @(posedge aclk); #1 areset = 1'b1; wr_valid = 1'b1; wr_data = wdata_for(16'h00AA, 2);
      @(posedge aclk); #1 areset = 1'b0;
      @(negedge aclk);
      chk("rst2_awvalid", awvalid, 0);
      chk("rst2_wvalid", wvalid, 0);
      chk("rst2_wr_ready", wr_ready, 0);
      chk("rst2_bready", bready, 0);
      chk("rst2_done_valid", done_valid, 0);
      @(posedge aclk); #1 wr_valid = 1'b0;
      @(negedge aclk);
      chk("rst2_cmd_ready", cmd_ready, 1);
      chk("rst2_aw_left", exp_aw.size(), 0);
      chk("rst2_w_left", exp_w.size(), 0);
    end
    r0 = n_r;
    run_read(32'h4000, 4'd3, 0, 1'b0, -1, 2'b00, -1, MY_ID, 0);
    chk("t10_beats", n_r - r0, 4);
    chk("t10_resp", last_done_resp, 2'b00);

    // 4KB page cases: 0xFC0+128 crosses, 0xF80+128 ends exactly on the page.
    aw0 = n_aw; w0 = n_w;
    run_write(32'hFC0, 4'd15, 16'h0FC0, 0, 0, 1'b0, 2'b00, MY_ID, 0);
`ifdef AXI_BURST_MASTER_4K_CHECK_EN
    chk("t11_aw_count", n_aw - aw0, 0);
    chk("t11_beats", n_w - w0, 0);
    chk("t11_resp", last_done_resp, 2'b10);
`else
    chk("t11_aw_count", n_aw - aw0, 1);
    chk("t11_beats", n_w - w0, 16);
    chk("t11_resp", last_done_resp, 2'b00);
`endif
    aw0 = n_aw; w0 = n_w;
    run_write(32'hF80, 4'd15, 16'h0F80, 1, 0, 1'b0, 2'b00, MY_ID, 0);
    chk("t12_aw_count", n_aw - aw0, 1);
    chk("t12_beats", n_w - w0, 16);
    chk("t12_resp", last_done_resp, 2'b00);

    repeat (3) @(posedge aclk);
    chk("end_aw_q", exp_aw.size(), 0);
    chk("end_w_q", exp_w.size(), 0);
    chk("end_ar_q", exp_ar.size(), 0);
    chk("end_rd_q", exp_rd.size(), 0);
    chk("end_done_q", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
